pe_network_interface: RTL and testbench

//   Network interface (NIC) between a processing element and the router's PE port.
//   The processor writes 64-bit packets into a one-entry output buffer; the NIC injects them on the PE input channel (pesi/pedi/peri).
//   The NIC captures packets ejected on the PE output channel (peso/pedo/pero) into a one-entry input buffer for the processor to read.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/nic_buffer.sv | 34 +++
 rtl/pe_network_interface.sv | 126 ++++++++++++
 tb/tb_pe_network_interface.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the PE network interface.
//   - Packet bit positions for the 64-bit NoC packet
//     (VC=63, NS=62, EW=61, YHOP=55:52, XHOP=51:48, SRC=47:32, DATA=31:0).
//   - Processor register addresses decoded by the NIC.
package noc_pkg;

    localparam int VC_BIT    = 63;
    localparam int NS_BIT    = 62;
    localparam int EW_BIT    = 61;
    localparam int Y_HOP_MSB = 55;
    localparam int Y_HOP_LSB = 52;
    localparam int X_HOP_MSB = 51;
    localparam int X_HOP_LSB = 48;
    localparam int SRC_MSB   = 47;
    localparam int SRC_LSB   = 32;
    localparam int DATA_MSB  = 31;
    localparam int DATA_LSB  = 0;

    localparam logic [1:0] ADDR_ICB      = 2'b00;
    localparam logic [1:0] ADDR_ICB_STAT = 2'b01;
    localparam logic [1:0] ADDR_OCB      = 2'b10;
    localparam logic [1:0] ADDR_OCB_STAT = 2'b11;

endpackage

// File: rtl/nic_buffer.sv
// nic_buffer: one-entry packet register with a full flag.
// Ports:
//   clk, reset   clock and synchronous active-high reset (clears data and flag)
//   load         capture d and mark full; wins over unload so a same-cycle
//                unload+load leaves the buffer full with the new packet
//   unload       clear the full flag (data is retained)
//   d            packet to capture
//   q            stored packet
//   full         buffer holds a valid packet
module nic_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_network_interface.sv
// pe_network_interface: NIC between a processing element and the router PE port.
// The processor writes packets into a one-entry output buffer (OCB) that is
// injected toward the router when its VC bit matches the router polarity; packets
// ejected by the router are captured into a one-entry input buffer (ICB).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   addr                register select: 00 ICB data, 01 ICB status,
//                       10 OCB data, 11 OCB status
//   d_in                processor write data
//   d_out               registered processor read data (1-cycle latency)
//   nicEn, nicWrEn      access enable / write select
//   net_polarity        router polarity
//   net_so, net_ro, net_do   injection channel (send, ready, data)
//   net_si, net_ri, net_di   ejection channel (send, ready, data)
//   irq                 only with NIC_IRQ_EN: high while ICB is full, plus a
//                       one-cycle pulse when an OCB write is dropped
// Build option: define NIC_IRQ_EN to add the irq output.
module pe_network_interface
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_polarity,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
`ifdef NIC_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic [DATA_WIDTH-1:0] ocb;
    logic [DATA_WIDTH-1:0] icb;
    logic                  ocb_full;
    logic                  icb_full;

    logic rd_en;
    logic ocb_wr_req;
    logic inject;
    logic ocb_load;
    logic ocb_drop;
    logic icb_load;
    logic icb_unload;

    assign rd_en = nicEn & ~nicWrEn;

    // An all-zero word means "no packet" on the network, so it is never queued.
    assign ocb_wr_req = nicEn & nicWrEn & (addr == ADDR_OCB) & (d_in != '0);

    // Each packet may only enter the router on the cycle whose polarity matches its VC.
    assign inject   = ocb_full & net_ro & (net_polarity == ocb[VC_BIT]);
    assign ocb_load = ocb_wr_req & (~ocb_full | inject);
    assign ocb_drop = ocb_wr_req & ocb_full & ~inject;

    assign net_so = inject;
    assign net_do = ocb_full ? ocb : '0;

    // net_ri is low whenever ICB is full, so a read of ICB and a new arrival
    // can never land on the same edge.
    assign net_ri     = ~icb_full;
    assign icb_load   = net_si & net_ri;
    assign icb_unload = rd_en & (addr == ADDR_ICB);

    nic_buffer #(.WIDTH(DATA_WIDTH)) u_ocb (
        .clk    (clk),
        .reset  (reset),
        .load   (ocb_load),
        .unload (inject),
        .d      (d_in),
        .q      (ocb),
        .full   (ocb_full)
    );

    nic_buffer #(.WIDTH(DATA_WIDTH)) u_icb (
        .clk    (clk),
        .reset  (reset),
        .load   (icb_load),
        .unload (icb_unload),
        .d      (net_di),
        .q      (icb),
        .full   (icb_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_ICB:      d_out <= icb_full ? icb : '0;
                ADDR_ICB_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, icb_full};
                ADDR_OCB:      d_out <= ocb;
                ADDR_OCB_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, ocb_full};
                default:       d_out <= '0;
            endcase
        end else begin
            d_out <= '0;
        end
    end

`ifdef NIC_IRQ_EN
    // irq follows the next-state ICB full flag so it changes on the same edge.
    logic icb_full_next;
    assign icb_full_next = icb_load | (icb_full & ~icb_unload);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= icb_full_next | ocb_drop;
        end
    end
`endif

endmodule

// File: tb/tb_pe_network_interface.sv
module tb_pe_network_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
`ifdef NIC_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pe_network_interface #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
`ifdef NIC_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two one-slot mailboxes plus a read register.
    logic [63:0] m_ocb = '0;
    bit          m_ocb_has = 1'b0;
    logic [63:0] m_icb = '0;
    bit          m_icb_has = 1'b0;
    logic [63:0] m_dout = '0;
    bit          m_irq = 1'b0;

    always @(posedge clk) begin
        bit send, was_icb, wr_ocb, dropped;
        if (reset) begin
            m_ocb = '0; m_ocb_has = 0; m_icb = '0; m_icb_has = 0;
            m_dout = '0; m_irq = 0;
        end else begin
            send    = m_ocb_has && net_ro && (net_polarity == m_ocb[63]);
            was_icb = m_icb_has;
            if (nicEn && !nicWrEn) begin
                if (addr == 2'd0)      m_dout = m_icb_has ? m_icb : 64'd0;
                else if (addr == 2'd1) m_dout = 64'(m_icb_has);
                else if (addr == 2'd2) m_dout = m_ocb;
                else                   m_dout = 64'(m_ocb_has);
            end else begin
                m_dout = '0;
            end
            if (send) m_ocb_has = 0;
            wr_ocb  = nicEn && nicWrEn && addr == 2'd2 && d_in != 0;
            dropped = 0;
            if (wr_ocb) begin
                if (!m_ocb_has) begin
                    m_ocb = d_in; m_ocb_has = 1;
                end else begin
                    dropped = 1;
                end
            end
            if (was_icb && nicEn && !nicWrEn && addr == 2'd0) m_icb_has = 0;
            if (!was_icb && net_si) begin
                m_icb = net_di; m_icb_has = 1;
            end
            m_irq = m_icb_has || dropped;
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_net_so", 64'(net_so),
                64'(m_ocb_has && net_ro && (net_polarity == m_ocb[63])));
            chk("m_net_do", net_do, m_ocb_has ? m_ocb : 64'd0);
            chk("m_net_ri", 64'(net_ri), 64'(!m_icb_has));
            chk("m_d_out", d_out, m_dout);
`ifdef NIC_IRQ_EN
            chk("m_irq", 64'(irq), 64'(m_irq));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] v);
        nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1; nicWrEn = 0; addr = a; d_in = '0;
    endtask

    initial begin
        reset = 1; idle();
        net_polarity = 0; net_ro = 0; net_si = 0; net_di = '0;
        cyc(); cyc();
        reset = 0;
        started = 1;
        @(negedge clk);
        chk("rst_net_ri", 64'(net_ri), 64'd1);
        chk("rst_net_so", 64'(net_so), 64'd0);
        chk("rst_d_out", d_out, 64'd0);
        chk("rst_net_do", net_do, 64'd0);
        cyc();

        // Injection gated by polarity
        net_ro = 1; net_polarity = 0;
        wr(2'd2, 64'h8000_0000_0000_00AA);
        cyc();
        idle();
        @(negedge clk);
        chk("pol_mismatch_so", 64'(net_so), 64'd0);
        chk("pol_mismatch_do", net_do, 64'h8000_0000_0000_00AA);
        cyc();
        net_polarity = 1;
        @(negedge clk);
        chk("inject_so", 64'(net_so), 64'd1);
        chk("inject_do", net_do, 64'h8000_0000_0000_00AA);
        cyc();
        net_polarity = 0;
        rd(2'd3);
        @(negedge clk);
        chk("after_inject_do", net_do, 64'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("ocb_empty_stat", d_out, 64'd0);

        // Write while full and blocked is dropped
        net_ro = 0;
        wr(2'd2, 64'h0000_0000_0000_00C1);
        cyc();
        wr(2'd2, 64'h0000_0000_0000_0001);
        cyc();
`ifdef NIC_IRQ_EN
        @(negedge clk);
        chk("drop_irq_hi", 64'(irq), 64'd1);
`endif
        rd(2'd3);
        cyc();
        @(negedge clk);
        chk("drop_stat", d_out, 64'd1);
`ifdef NIC_IRQ_EN
        chk("drop_irq_lo", 64'(irq), 64'd0);
`endif
        rd(2'd2);
        cyc();
        idle();
        @(negedge clk);
        chk("drop_keep_data", d_out, 64'h0000_0000_0000_00C1);
        net_ro = 1; net_polarity = 0;
        cyc();
        net_ro = 0;

        // Ejection capture and read
        net_si = 1; net_di = 64'h0000_0000_0000_1234;
        cyc();
        net_di = 64'h0000_0000_0000_5678;
        @(negedge clk);
        chk("icb_full_ri", 64'(net_ri), 64'd0);
        cyc();
        net_si = 0; net_di = '0;
        rd(2'd1);
        cyc();
        rd(2'd0);
        @(negedge clk);
        chk("icb_stat", d_out, 64'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("icb_read", d_out, 64'h0000_0000_0000_1234);
        chk("icb_ri_back", 64'(net_ri), 64'd1);
        cyc();

        // Inject coincident with reload
        net_ro = 1; net_polarity = 1;
        wr(2'd2, 64'h0000_0000_0000_00A5);
        cyc();
        net_polarity = 0;
        wr(2'd2, 64'h8000_0000_0000_00BB);
        @(negedge clk);
        chk("b2b_so_a5", 64'(net_so), 64'd1);
        chk("b2b_do_a5", net_do, 64'h0000_0000_0000_00A5);
        cyc();
        idle();
        @(negedge clk);
        chk("b2b_hold_so", 64'(net_so), 64'd0);
        chk("b2b_hold_do", net_do, 64'h8000_0000_0000_00BB);
        cyc();
        net_polarity = 1;
        @(negedge clk);
        chk("b2b_so_bb", 64'(net_so), 64'd1);
        cyc();
        net_polarity = 0;
        @(negedge clk);
        chk("b2b_drained", net_do, 64'd0);

        // Empty ICB read, ignored writes
        rd(2'd0);
        cyc();
        wr(2'd1, 64'hFF);
        @(negedge clk);
        chk("empty_icb_rd", d_out, 64'd0);
        chk("empty_icb_ri", 64'(net_ri), 64'd1);
        cyc();
        wr(2'd2, 64'd0);
        cyc();
        rd(2'd1);
        cyc();
        rd(2'd3);
        @(negedge clk);
        chk("wr01_ignored", d_out, 64'd0);
        cyc();
        nicEn = 0; nicWrEn = 1; addr = 2'd2; d_in = 64'h55;
        @(negedge clk);
        chk("zero_wr_ignored", d_out, 64'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("wren_no_en", net_do, 64'd0);

        // Reset in the middle of traffic
        net_ro = 0;
        wr(2'd2, 64'h0000_0000_0000_0077);
        net_si = 1; net_di = 64'h0000_0000_0000_0099;
        cyc();
        reset = 1;
        rd(2'd2);
        cyc(); cyc();
        reset = 0; idle(); net_si = 0; net_di = '0;
        net_ro = 1; net_polarity = 0;
        @(negedge clk);
        chk("mid_rst_ri", 64'(net_ri), 64'd1);
        chk("mid_rst_so", 64'(net_so), 64'd0);
        chk("mid_rst_do", net_do, 64'd0);
        chk("mid_rst_dout", d_out, 64'd0);
        rd(2'd1);
        cyc();
        rd(2'd3);
        @(negedge clk);
        chk("mid_rst_icb_stat", d_out, 64'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("mid_rst_ocb_stat", d_out, 64'd0);
        cyc();

        started = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
